// File: rtl/cpu_register_file.sv
// 6502-style register set (A, X, Y, SP, PC, P) with SP/PC stepping and masked flag update.
// Optional sticky stack guard flags are built when CPU_REGFILE_STACK_GUARD_EN is defined.
module cpu_register_file #(
    parameter int               DW           = 8,
    parameter int               AW           = 16,
    parameter logic [DW-1:0]    RST_SP       = 8'hFF,
    parameter logic [AW-1:0]    RST_PC       = 16'h0200,
    parameter logic [DW-1:0]    RST_P        = 8'h20,
    parameter logic [DW-1:0]    P_FIXED_MASK = 8'h00,
    parameter logic [DW-1:0]    P_FIXED_VAL  = 8'h20,
    parameter logic [AW-DW-1:0] STACK_PAGE   = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] addr_in,
    input  logic          a_write,
    input  logic          x_write,
    input  logic          y_write,
    input  logic          sp_write,
    input  logic          sp_inc,
    input  logic          sp_dec,
    input  logic          pc_write,
    input  logic          pc_inc,
    input  logic [1:0]    pc_step,
    input  logic          p_write,
    input  logic          flag_we,
    input  logic [DW-1:0] flag_mask,
    input  logic [DW-1:0] flag_in,
    output logic [DW-1:0] reg_a,
    output logic [DW-1:0] reg_x,
    output logic [DW-1:0] reg_y,
    output logic [DW-1:0] reg_sp,
    output logic [DW-1:0] reg_p,
    output logic [AW-1:0] reg_pc,
    output logic [AW-1:0] stack_addr,
    output logic          sp_overflow,
    output logic          sp_underflow
);

    localparam logic [DW-1:0] P_RST_EFF = (RST_P & ~P_FIXED_MASK) | (P_FIXED_VAL & P_FIXED_MASK);

    logic [DW-1:0] a_q, a_d, x_q, x_d, y_q, y_d, sp_q, sp_d, p_q, p_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] p_next;
    logic          sp_up, sp_down;

    // A simultaneous inc and dec cancels out, so neither counts as a step.
    assign sp_up   = !sp_write && sp_inc && !sp_dec;
    assign sp_down = !sp_write && sp_dec && !sp_inc;

    always_comb begin
        a_d    = a_write ? data_in : a_q;
        x_d    = x_write ? data_in : x_q;
        y_d    = y_write ? data_in : y_q;

        sp_d   = sp_q;
        if (sp_write)     sp_d = data_in;
        else if (sp_up)   sp_d = sp_q + DW'(1);
        else if (sp_down) sp_d = sp_q - DW'(1);

        pc_d   = pc_q;
        if (pc_write)    pc_d = addr_in;
        else if (pc_inc) pc_d = pc_q + AW'(pc_step);

        p_next = p_q;
        if (p_write)      p_next = data_in;
        else if (flag_we) p_next = (p_q & ~flag_mask) | (flag_in & flag_mask);
        p_d    = (p_next & ~P_FIXED_MASK) | (P_FIXED_VAL & P_FIXED_MASK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            x_q  <= '0;
            y_q  <= '0;
            sp_q <= RST_SP;
            pc_q <= RST_PC;
            p_q  <= P_RST_EFF;
        end else begin
            a_q  <= a_d;
            x_q  <= x_d;
            y_q  <= y_d;
            sp_q <= sp_d;
            pc_q <= pc_d;
            p_q  <= p_d;
        end
    end

`ifdef CPU_REGFILE_STACK_GUARD_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (sp_write) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (sp_down && sp_q == '0) ovf_d = 1'b1;
            if (sp_up && sp_q == '1)   unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sp_overflow  = ovf_q;
    assign sp_underflow = unf_q;
`else
    assign sp_overflow  = 1'b0;
    assign sp_underflow = 1'b0;
`endif

    assign reg_a      = a_q;
    assign reg_x      = x_q;
    assign reg_y      = y_q;
    assign reg_sp     = sp_q;
    assign reg_pc     = pc_q;
    assign reg_p      = p_q;
    assign stack_addr = {STACK_PAGE, sp_q};

endmodule

// File: tb/tb_cpu_register_file.sv
// Bench for cpu_register_file: default instance plus one with P bit 5 forced, both
// checked every cycle against a behavioural model, with directed literal checks.
module tb_cpu_register_file;

`ifdef CPU_REGFILE_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        int a, x, y, sp, pc, p;
        bit ovf, unf;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic [15:0] addr_in = '0;
    logic        a_write = 0, x_write = 0, y_write = 0, sp_write = 0, sp_inc = 0, sp_dec = 0;
    logic        pc_write = 0, pc_inc = 0, p_write = 0, flag_we = 0;
    logic [1:0]  pc_step = '0;
    logic [7:0]  flag_mask = '0, flag_in = '0;

    logic [7:0]  r_a [2], r_x [2], r_y [2], r_sp [2], r_p [2];
    logic [15:0] r_pc [2], r_stk [2];
    logic        r_ovf [2], r_unf [2];

    model_t m [2];
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    cpu_register_file dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in),
        .a_write(a_write), .x_write(x_write), .y_write(y_write),
        .sp_write(sp_write), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .pc_write(pc_write), .pc_inc(pc_inc), .pc_step(pc_step),
        .p_write(p_write), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
        .reg_a(r_a[0]), .reg_x(r_x[0]), .reg_y(r_y[0]), .reg_sp(r_sp[0]), .reg_p(r_p[0]),
        .reg_pc(r_pc[0]), .stack_addr(r_stk[0]),
        .sp_overflow(r_ovf[0]), .sp_underflow(r_unf[0])
    );

    cpu_register_file #(.P_FIXED_MASK(8'h20)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in),
        .a_write(a_write), .x_write(x_write), .y_write(y_write),
        .sp_write(sp_write), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .pc_write(pc_write), .pc_inc(pc_inc), .pc_step(pc_step),
        .p_write(p_write), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
        .reg_a(r_a[1]), .reg_x(r_x[1]), .reg_y(r_y[1]), .reg_sp(r_sp[1]), .reg_p(r_p[1]),
        .reg_pc(r_pc[1]), .stack_addr(r_stk[1]),
        .sp_overflow(r_ovf[1]), .sp_underflow(r_unf[1])
    );

    function automatic int fixed_mask(int i);
        return (i == 1) ? 'h20 : 'h00;
    endfunction

    function automatic int force_p(int i, int v);
        return (v & ~fixed_mask(i) & 'hFF) | ('h20 & fixed_mask(i));
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].a = 0; m[i].x = 0; m[i].y = 0;
            m[i].sp = 'hFF; m[i].pc = 'h0200;
            m[i].p = force_p(i, 'h20);
            m[i].ovf = 0; m[i].unf = 0;
        end
    endtask

    // Next state computed from the architectural rules with integer arithmetic.
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            model_t s = m[i];
            model_t n = m[i];
            int flags;
            if (a_write) n.a = int'(data_in);
            if (x_write) n.x = int'(data_in);
            if (y_write) n.y = int'(data_in);
            if (sp_write) begin
                n.sp = int'(data_in);
                n.ovf = 0;
                n.unf = 0;
            end else if (sp_inc && !sp_dec) begin
                n.sp = (s.sp + 1) % 256;
                if (GUARD && s.sp == 255) n.unf = 1;
            end else if (sp_dec && !sp_inc) begin
                n.sp = (s.sp + 255) % 256;
                if (GUARD && s.sp == 0) n.ovf = 1;
            end
            if (pc_write) n.pc = int'(addr_in);
            else if (pc_inc) n.pc = (s.pc + int'(pc_step)) % 65536;
            flags = s.p;
            if (p_write) flags = int'(data_in);
            else if (flag_we) flags = (s.p & ~int'(flag_mask) & 'hFF) | int'(flag_in & flag_mask);
            n.p = force_p(i, flags);
            m[i] = n;
        end
    endtask

    task automatic idle();
        a_write = 0; x_write = 0; y_write = 0; sp_write = 0; sp_inc = 0; sp_dec = 0;
        pc_write = 0; pc_inc = 0; pc_step = 0; p_write = 0; flag_we = 0;
        flag_mask = 0; flag_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cyc_a%0d", i),   int'(r_a[i]),   m[i].a);
                check($sformatf("cyc_x%0d", i),   int'(r_x[i]),   m[i].x);
                check($sformatf("cyc_y%0d", i),   int'(r_y[i]),   m[i].y);
                check($sformatf("cyc_sp%0d", i),  int'(r_sp[i]),  m[i].sp);
                check($sformatf("cyc_pc%0d", i),  int'(r_pc[i]),  m[i].pc);
                check($sformatf("cyc_p%0d", i),   int'(r_p[i]),   m[i].p);
                check($sformatf("cyc_stk%0d", i), int'(r_stk[i]), 'h0100 + m[i].sp);
                check($sformatf("cyc_ovf%0d", i), int'(r_ovf[i]), int'(m[i].ovf));
                check($sformatf("cyc_unf%0d", i), int'(r_unf[i]), int'(m[i].unf));
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        check_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_a", int'(r_a[0]), 'h00);
        check("rst_x", int'(r_x[0]), 'h00);
        check("rst_y", int'(r_y[0]), 'h00);
        check("rst_sp", int'(r_sp[0]), 'hFF);
        check("rst_pc", int'(r_pc[0]), 'h0200);
        check("rst_p", int'(r_p[0]), 'h20);
        check("rst_stk", int'(r_stk[0]), 'h01FF);

        data_in = 8'h77; addr_in = 16'h5678;
        a_write = 1; x_write = 1; y_write = 1; sp_write = 1; pc_write = 1; p_write = 1;
        tick();
        idle();
        check("all_a", int'(r_a[0]), 'h77);
        check("all_sp", int'(r_sp[0]), 'h77);
        check("all_pc", int'(r_pc[0]), 'h5678);
        check("all_p", int'(r_p[0]), 'h77);
        check("model_p1", m[1].p, 'h77);
        tick();
        check("hold_x", int'(r_x[0]), 'h77);
        check("hold_pc", int'(r_pc[0]), 'h5678);

        data_in = 8'h00; sp_write = 1; tick(); idle();
        sp_dec = 1; tick(); idle();
        check("dec_wrap_sp", int'(r_sp[0]), 'hFF);
        check("dec_wrap_stk", int'(r_stk[0]), 'h01FF);
        check("dec_ovf", int'(r_ovf[0]), int'(GUARD));
        sp_inc = 1; tick(); idle();
        check("inc_wrap_sp", int'(r_sp[0]), 'h00);
        check("inc_unf", int'(r_unf[0]), int'(GUARD));
        sp_inc = 1; sp_dec = 1; tick(); idle();
        check("incdec_sp", int'(r_sp[0]), 'h00);
        data_in = 8'h80; sp_write = 1; sp_dec = 1; tick(); idle();
        check("spw_sp", int'(r_sp[0]), 'h80);
        check("spw_ovf", int'(r_ovf[0]), 0);
        check("spw_unf", int'(r_unf[0]), 0);

        addr_in = 16'hFFFE; pc_write = 1; tick(); idle();
        pc_inc = 1; pc_step = 2'd3; tick(); idle();
        check("pc_wrap", int'(r_pc[0]), 'h0001);
        pc_inc = 1; pc_step = 2'd0; tick(); idle();
        check("pc_step0", int'(r_pc[0]), 'h0001);
        addr_in = 16'h1234; pc_write = 1; pc_inc = 1; pc_step = 2'd2; tick(); idle();
        check("pc_write_wins", int'(r_pc[0]), 'h1234);

        data_in = 8'hC3; p_write = 1; tick(); idle();
        flag_we = 1; flag_mask = 8'h03; flag_in = 8'h01; tick(); idle();
        check("flag_masked", int'(r_p[0]), 'hC1);
        check("flag_forced", int'(r_p[1]), 'hE1);
        data_in = 8'h5A; p_write = 1; flag_we = 1; flag_mask = 8'hFF; flag_in = 8'h00; tick(); idle();
        check("pwrite_wins", int'(r_p[0]), 'h5A);
        check("pwrite_forced", int'(r_p[1]), 'h7A);

        data_in = 8'h00; p_write = 1; tick(); idle();
        check("p_forced_zero", int'(r_p[1]), 'h20);
        check("p_plain_zero", int'(r_p[0]), 'h00);

        data_in = 8'h55; a_write = 1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_a", int'(r_a[0]), 'h00);
        check("async_rst_p1", int'(r_p[1]), 'h20);
        tick();
        check("rst_blocks_write", int'(r_a[0]), 'h00);
        idle();
        rst = 1'b0;
        tick();

        for (int c = 0; c < 600; c++) begin
            data_in   = 8'($urandom_range(0, 255));
            addr_in   = 16'($urandom_range(0, 65535));
            a_write   = ($urandom_range(0, 3) == 0);
            x_write   = ($urandom_range(0, 3) == 0);
            y_write   = ($urandom_range(0, 3) == 0);
            sp_write  = ($urandom_range(0, 9) == 0);
            if (sp_write && $urandom_range(0, 1) == 1) data_in = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            sp_inc    = ($urandom_range(0, 2) == 0);
            sp_dec    = ($urandom_range(0, 2) == 0);
            pc_write  = ($urandom_range(0, 7) == 0);
            if (pc_write && $urandom_range(0, 1) == 1) addr_in = 16'hFFFD + 16'($urandom_range(0, 2));
            pc_inc    = ($urandom_range(0, 1) == 1);
            pc_step   = 2'($urandom_range(0, 3));
            p_write   = ($urandom_range(0, 7) == 0);
            flag_we   = ($urandom_range(0, 2) == 0);
            flag_mask = 8'($urandom_range(0, 255));
            flag_in   = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        tick();
        check_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
